// File: rtl/tc77_pkg.sv
// Shared types and frame layout for the TC77 reader.
// TC77_CONFIG_WR_EN widens the frame to 32 clocks so a config word can be written.
package tc77_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HI,
        ST_LO,
        ST_HOLD,
        ST_DONE
    } state_t;

`ifdef TC77_CONFIG_WR_EN
    localparam int unsigned FRAME_BITS = 32;
`else
    localparam int unsigned FRAME_BITS = 16;
`endif

    localparam int unsigned READ_BITS  = 16;
    localparam int unsigned TEMP_MSB   = 15;
    localparam int unsigned TEMP_LSB   = 3;
    localparam int unsigned FLAG_BIT   = 2;
    localparam int unsigned TEMPDATA_W = 14;
    localparam int unsigned CFG_W      = 16;

    function automatic logic [TEMPDATA_W-1:0] frame_to_tempdata(
        input logic [TEMP_MSB:FLAG_BIT] frame
    );
        return {frame[TEMP_MSB:TEMP_LSB], frame[FLAG_BIT]};
    endfunction

endpackage

// File: rtl/tc77_reader_if.sv
// Host handshake plus TC77 nCS/CLK pins; SIO stays a plain inout on the reader.
// CFGWORD exists only when TC77_CONFIG_WR_EN is defined.
interface tc77_reader_if;
    import tc77_pkg::*;

    logic                  nLOAD;
    logic [TEMPDATA_W-1:0] TEMPDATA;
    logic                  nCOMPLETE;
    logic                  nBUSY;
    logic                  nCS;
    logic                  CLK;
`ifdef TC77_CONFIG_WR_EN
    logic [CFG_W-1:0]      CFGWORD;
`endif

    modport master (
`ifdef TC77_CONFIG_WR_EN
        output CFGWORD,
`endif
        output nLOAD,
        input  TEMPDATA, nCOMPLETE, nBUSY, nCS, CLK
    );

    modport slave (
`ifdef TC77_CONFIG_WR_EN
        input  CFGWORD,
`endif
        input  nLOAD,
        output TEMPDATA, nCOMPLETE, nBUSY, nCS, CLK
    );

endinterface

// File: rtl/tc77_sck_gen.sv
// Half-period timer for the TC77 serial clock: start opens a high phase,
// tick marks the last MCLK cycle of each phase, stop parks CLK low.
module tc77_sck_gen #(
    parameter int unsigned HALF_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    output logic sck,
    output logic tick
);
    localparam int unsigned CNT_W = $clog2(HALF_DIV);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             run;

    assign tick = run && (cnt == CNT_END);

    // stop wins over the phase toggle so the final low phase does not turn into a high one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            sck <= 1'b0;
            cnt <= '0;
        end else if (stop) begin
            run <= 1'b0;
            sck <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            sck <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            if (tick) begin
                cnt <= '0;
                sck <= ~sck;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc77_reader.sv
// TC77 read-frame engine: one nLOAD pulse -> one nCS frame -> TEMPDATA + nCOMPLETE strobe.
// TC77_CONFIG_WR_EN adds a 16-clock CFGWORD write phase after the read bits.
module tc77_reader
    import tc77_pkg::*;
#(
    parameter int unsigned HALF_DIV = 8,
    parameter int unsigned CS_SETUP = 8,
    parameter int unsigned CS_HOLD  = 16
) (
    input  logic         MCLK,
    input  logic         nRESET,
    tc77_reader_if.slave bus,
    inout  wire          SIO
);
    localparam int unsigned WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned BIT_W    = $clog2(FRAME_BITS + 1);

    localparam logic [WAIT_W-1:0] SETUP_END = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] HOLD_END  = WAIT_W'(CS_HOLD);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_BITS);
    localparam logic [BIT_W-1:0]  READ_END  = BIT_W'(READ_BITS);

    state_t                state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [READ_BITS-1:0]  shreg;
    logic                  sio_meta;
    logic                  sio_sync;
    logic                  ncs;
    logic                  nbusy;
    logic                  ncomplete;
    logic [TEMPDATA_W-1:0] tempdata;
    logic                  gen_start;
    logic                  gen_stop;
    logic                  sck;
    logic                  tick;

`ifdef TC77_CONFIG_WR_EN
    localparam logic [BIT_W-1:0] WR_FIRST = BIT_W'(READ_BITS - 1);

    logic [CFG_W-1:0] cfg_sh;
    logic             sio_oe;
    logic             sio_out;

    assign SIO = sio_oe ? sio_out : 1'bz;
`else
    assign SIO = 1'bz;
`endif

    assign bus.nCS       = ncs;
    assign bus.CLK       = sck;
    assign bus.nBUSY     = nbusy;
    assign bus.nCOMPLETE = ncomplete;
    assign bus.TEMPDATA  = tempdata;

    assign gen_start = (state == ST_SETUP) && (wait_cnt == SETUP_END);
    assign gen_stop  = (state == ST_LO) && tick && (bit_cnt == LAST_BIT);

    tc77_sck_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sck_gen (
        .clk   (MCLK),
        .rst_n (nRESET),
        .start (gen_start),
        .stop  (gen_stop),
        .sck   (sck),
        .tick  (tick)
    );

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            sio_meta <= 1'b0;
            sio_sync <= 1'b0;
        end else begin
            sio_meta <= SIO;
            sio_sync <= sio_meta;
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ncs       <= 1'b1;
            nbusy     <= 1'b1;
            ncomplete <= 1'b1;
            tempdata  <= '0;
`ifdef TC77_CONFIG_WR_EN
            cfg_sh    <= '0;
            sio_oe    <= 1'b0;
            sio_out   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.nLOAD) begin
                        state    <= ST_SETUP;
                        ncs      <= 1'b0;
                        nbusy    <= 1'b0;
                        wait_cnt <= '0;
                        bit_cnt  <= '0;
                        shreg    <= '0;
`ifdef TC77_CONFIG_WR_EN
                        cfg_sh   <= bus.CFGWORD;
`endif
                    end
                end
                ST_SETUP: begin
                    if (wait_cnt == SETUP_END) begin
                        state <= ST_HI;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_HI: begin
                    if (tick) begin
                        state   <= ST_LO;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt < READ_END) begin
                            shreg <= {shreg[READ_BITS-2:0], sio_sync};
                        end
`ifdef TC77_CONFIG_WR_EN
                        // next write bit goes out as this high phase ends, so it is stable for the following high phase
                        if ((bit_cnt >= WR_FIRST) && (bit_cnt < LAST_BIT - 1'b1)) begin
                            sio_oe  <= 1'b1;
                            sio_out <= cfg_sh[CFG_W-1];
                            cfg_sh  <= {cfg_sh[CFG_W-2:0], 1'b0};
                        end
`endif
                    end
                end
                ST_LO: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state    <= ST_HOLD;
                            ncs      <= 1'b1;
                            wait_cnt <= '0;
`ifdef TC77_CONFIG_WR_EN
                            sio_oe   <= 1'b0;
`endif
                        end else begin
                            state <= ST_HI;
                        end
                    end
                end
                ST_HOLD: begin
                    if (wait_cnt == HOLD_END) begin
                        state     <= ST_DONE;
                        ncomplete <= 1'b0;
                        nbusy     <= 1'b1;
                        tempdata  <= frame_to_tempdata(shreg[TEMP_MSB:FLAG_BIT]);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ncomplete <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc77_reader.sv
// Self-checking bench for tc77_reader with a behavioural TC77 sensor model.
// Define TC77_CONFIG_WR_EN to also exercise the config-write frame.
module tb_tc77_reader;

    localparam int H  = 8;
    localparam int S  = 8;
    localparam int CH = 16;
`ifdef TC77_CONFIG_WR_EN
    localparam int NBITS = 32;
`else
    localparam int NBITS = 16;
`endif
    localparam int LAT    = S + 2 * NBITS * H + CH + 1;
    localparam int PERIOD = LAT + 2;

    logic mclk = 1'b0;
    logic nreset = 1'b0;
    logic sio_drv_en = 1'b0;
    logic sio_drv_val = 1'b0;
    wire  sio;

    int tests = 0;
    int fails = 0;

    logic [15:0] model_word = 16'h0000;

    tc77_reader_if bus ();

    assign sio = sio_drv_en ? sio_drv_val : 1'bz;

    tc77_reader #(
        .HALF_DIV (H),
        .CS_SETUP (S),
        .CS_HOLD  (CH)
    ) dut (
        .MCLK   (mclk),
        .nRESET (nreset),
        .bus    (bus),
        .SIO    (sio)
    );

    always #5 mclk = ~mclk;

    function automatic logic [13:0] ref_temp(input logic [15:0] w);
        // sign + 12 magnitude bits, then the conversion flag; two junk LSBs dropped
        return w[15:2];
    endfunction

    // Sensor model and per-frame protocol monitor, sampled on the falling MCLK edge.
    logic        prev_ncs = 1'b1;
    logic        prev_clk = 1'b0;
    int          rises = 0;
    int          cyc = 0;
    int          last_edge = 0;
    int          first_rise = -1;
    int          bad_half = 0;
    int          idle_clk_bad = 0;
    int          tc_bit = 0;
    logic [15:0] cfg_cap = 16'h0000;

    always @(negedge mclk) begin
        if (nreset !== 1'b1) begin
            prev_ncs   = 1'b1;
            prev_clk   = 1'b0;
            sio_drv_en = 1'b0;
        end else begin
            if (bus.nCS === 1'b1 && bus.CLK !== 1'b0) idle_clk_bad++;
            if (prev_ncs && !bus.nCS) begin
                rises = 0; cyc = 0; last_edge = 0; first_rise = -1; bad_half = 0; tc_bit = 0;
                sio_drv_en  = 1'b1;
                sio_drv_val = model_word[15];
`ifdef TC77_CONFIG_WR_EN
                cfg_cap = bus.CFGWORD;
`endif
            end else if (!bus.nCS) begin
                cyc++;
                if (bus.CLK && !prev_clk) begin
                    rises++;
                    if (rises == 1) first_rise = cyc;
                    else if (cyc - last_edge != H) bad_half++;
                    last_edge = cyc;
`ifdef TC77_CONFIG_WR_EN
                    if (rises > 16 && rises <= 32) begin
                        tests++;
                        if (sio !== cfg_cap[32 - rises]) begin
                            fails++;
                            $display("FAIL cfg_sio edge %0d: got %b expected %b", rises, sio, cfg_cap[32 - rises]);
                        end
                    end
`endif
                end else if (!bus.CLK && prev_clk) begin
                    if (cyc - last_edge != H) bad_half++;
                    last_edge = cyc;
                    tc_bit++;
                    if (tc_bit < 16) sio_drv_val = model_word[15 - tc_bit];
                    else sio_drv_en = 1'b0;
                end
            end else begin
                sio_drv_en = 1'b0;
            end
            if (!prev_ncs && bus.nCS) begin
                tests++;
                if (rises != NBITS) begin
                    fails++;
                    $display("FAIL clk_edges: got %0d rising edges expected %0d", rises, NBITS);
                end
                tests++;
                if (first_rise != S) begin
                    fails++;
                    $display("FAIL cs_setup: first rise after %0d cycles expected %0d", first_rise, S);
                end
                tests++;
                if (bad_half != 0) begin
                    fails++;
                    $display("FAIL half_period: %0d phases not %0d cycles long", bad_half, H);
                end
                tests++;
                if (idle_clk_bad != 0) begin
                    fails++;
                    $display("FAIL clk_idle: CLK high with nCS high in %0d cycles, expected 0", idle_clk_bad);
                end
            end
            prev_ncs = bus.nCS;
            prev_clk = bus.CLK;
        end
    end

    task automatic run_frame(input logic [15:0] word, input logic [13:0] exp, input string tag);
        int lat;
        int busy_bad;
        int td_bad;
        logic [13:0] prev_td;
        model_word = word;
        @(negedge mclk); bus.nLOAD = 1'b0;
        @(negedge mclk); bus.nLOAD = 1'b1;
        lat = 1; busy_bad = 0; td_bad = 0; prev_td = bus.TEMPDATA;
        while (bus.nCOMPLETE !== 1'b0 && lat < 2000) begin
            if (bus.nBUSY !== 1'b0) busy_bad++;
            if (bus.TEMPDATA !== prev_td) td_bad++;
            @(negedge mclk); lat++;
        end
        tests++;
        if (lat - 1 != LAT) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles expected %0d", tag, lat - 1, LAT);
        end
        tests++;
        if (bus.TEMPDATA !== exp) begin
            fails++;
            $display("FAIL %s tempdata: got %h expected %h", tag, bus.TEMPDATA, exp);
        end
        tests++;
        if (bus.nBUSY !== 1'b1) begin
            fails++;
            $display("FAIL %s nbusy_at_done: got %b expected 1", tag, bus.nBUSY);
        end
        tests++;
        if (busy_bad != 0 || td_bad != 0) begin
            fails++;
            $display("FAIL %s in_frame: busy_high=%0d tempdata_changed=%0d expected 0/0", tag, busy_bad, td_bad);
        end
        @(negedge mclk);
        tests++;
        if (bus.nCOMPLETE !== 1'b1) begin
            fails++;
            $display("FAIL %s complete_width: nCOMPLETE %b one cycle later, expected 1", tag, bus.nCOMPLETE);
        end
    endtask

    task automatic test_reset();
        bus.nLOAD = 1'b1;
        nreset = 1'b0;
        repeat (3) @(negedge mclk);
        tests++;
        if ({bus.nCS, bus.CLK, bus.nCOMPLETE, bus.nBUSY, bus.TEMPDATA} !== {4'b1011, 14'h0000}) begin
            fails++;
            $display("FAIL reset_state: got ncs=%b clk=%b ncomp=%b nbusy=%b td=%h expected 1 0 1 1 0000",
                     bus.nCS, bus.CLK, bus.nCOMPLETE, bus.nBUSY, bus.TEMPDATA);
        end
        nreset = 1'b1;
        repeat (3) @(negedge mclk);
    endtask

    task automatic test_known_values();
        run_frame(16'h0C87, 14'h0321, "plus25");
        repeat (4) @(negedge mclk);
        run_frame(16'hFB07, 14'h3EC1, "minus10");
        repeat (4) @(negedge mclk);
        run_frame(16'h0C83, 14'h0320, "flag0");
    endtask

    task automatic test_random_frames();
        logic [15:0] w;
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge mclk);
            run_frame(w, ref_temp(w), "random");
        end
    endtask

    task automatic test_ignored_loads();
        int starts = 0;
        int comps = 0;
        int comp_at = -1;
        logic pn;
        model_word = 16'($urandom);
        pn = bus.nCS;
        for (int j = 0; j < LAT + 300; j++) begin
            @(negedge mclk);
            if (pn && !bus.nCS) starts++;
            if (bus.nCOMPLETE === 1'b0) begin comps++; comp_at = j - 1; end
            pn = bus.nCS;
            bus.nLOAD = (j == 0 || j == 5 || j == 40 || j == LAT || j == LAT + 1) ? 1'b0 : 1'b1;
        end
        bus.nLOAD = 1'b1;
        tests++;
        if (starts != 1 || comps != 1) begin
            fails++;
            $display("FAIL ignored_loads: got %0d frames %0d completions expected 1 1", starts, comps);
        end
        tests++;
        if (comp_at != LAT) begin
            fails++;
            $display("FAIL ignored_loads latency: got %0d expected %0d", comp_at, LAT);
        end
        tests++;
        if (bus.TEMPDATA !== ref_temp(model_word)) begin
            fails++;
            $display("FAIL ignored_loads tempdata: got %h expected %h", bus.TEMPDATA, ref_temp(model_word));
        end
    endtask

    task automatic test_held_low();
        int starts = 0;
        int comps = 0;
        int gap = 0;
        int min_gap = 100000;
        int td_bad = 0;
        int k;
        logic pn;
        model_word = 16'($urandom);
        pn = bus.nCS;
        bus.nLOAD = 1'b0;
        for (int j = 0; j < 2 * PERIOD + 134; j++) begin
            @(negedge mclk);
            if (pn && !bus.nCS) begin
                starts++;
                if (starts > 1 && gap < min_gap) min_gap = gap;
            end
            if (bus.nCS) gap++;
            else gap = 0;
            if (bus.nCOMPLETE === 1'b0) begin
                comps++;
                if (bus.TEMPDATA !== ref_temp(model_word)) td_bad++;
            end
            pn = bus.nCS;
        end
        bus.nLOAD = 1'b1;
        tests++;
        if (starts != 3 || comps != 2) begin
            fails++;
            $display("FAIL held_low: got %0d frames %0d completions expected 3 2", starts, comps);
        end
        tests++;
        if (min_gap < CH + 2) begin
            fails++;
            $display("FAIL held_low gap: nCS high %0d cycles expected at least %0d", min_gap, CH + 2);
        end
        tests++;
        if (td_bad != 0) begin
            fails++;
            $display("FAIL held_low tempdata: %0d wrong words expected 0", td_bad);
        end
        k = 0;
        while (bus.nCOMPLETE !== 1'b0 && k < 2000) begin @(negedge mclk); k++; end
        tests++;
        if (k >= 2000) begin
            fails++;
            $display("FAIL held_low drain: no completion within %0d cycles", k);
        end
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_reset_mid_frame();
        int r = 0;
        int k = 0;
        int bad = 0;
        logic pc;
        run_frame(16'h0C87, 14'h0321, "pre_reset");
        repeat (3) @(negedge mclk);
        model_word = 16'($urandom);
        @(negedge mclk); bus.nLOAD = 1'b0;
        @(negedge mclk); bus.nLOAD = 1'b1;
        pc = bus.CLK;
        while (r < 9 && k < 1000) begin
            @(negedge mclk); k++;
            if (bus.CLK && !pc) r++;
            pc = bus.CLK;
        end
        tests++;
        if (r != 9) begin
            fails++;
            $display("FAIL reset_mid reach_bit9: got %0d rising edges expected 9", r);
        end
        nreset = 1'b0;
        #1;
        tests++;
        if ({bus.nCS, bus.CLK, bus.nCOMPLETE, bus.nBUSY, bus.TEMPDATA} !== {4'b1011, 14'h0000}) begin
            fails++;
            $display("FAIL reset_mid state: got ncs=%b clk=%b ncomp=%b nbusy=%b td=%h expected 1 0 1 1 0000",
                     bus.nCS, bus.CLK, bus.nCOMPLETE, bus.nBUSY, bus.TEMPDATA);
        end
        repeat (2) @(negedge mclk);
        nreset = 1'b1;
        for (int j = 0; j < LAT + 50; j++) begin
            @(negedge mclk);
            if (bus.nCOMPLETE !== 1'b1 || bus.nCS !== 1'b1 || bus.TEMPDATA !== 14'h0000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid quiet: %0d cycles with activity after abort, expected 0", bad);
        end
        run_frame(16'hFB07, 14'h3EC1, "post_reset");
    endtask

`ifdef TC77_CONFIG_WR_EN
    task automatic test_config_write();
        logic [15:0] w;
        bus.CFGWORD = 16'hFFFF;
        repeat (3) @(negedge mclk);
        run_frame(16'h0C87, 14'h0321, "cfg_shutdown");
        w = 16'($urandom);
        bus.CFGWORD = 16'($urandom);
        repeat (3) @(negedge mclk);
        run_frame(w, ref_temp(w), "cfg_random");
        bus.CFGWORD = 16'h0000;
    endtask
`endif

    initial begin
        bus.nLOAD = 1'b1;
`ifdef TC77_CONFIG_WR_EN
        bus.CFGWORD = 16'h0000;
`endif
        test_reset();
        test_known_values();
        test_random_frames();
        test_ignored_loads();
        test_held_low();
        test_reset_mid_frame();
`ifdef TC77_CONFIG_WR_EN
        test_config_write();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
